unidade_controle: RTL
=====================

# unidade_controle

Moore control unit for the memory-sequence game: it sequences the game datapath's address counter, round-limit counter, play register and play timer, and decides hit/miss/timeout from the datapath's status flags. It sits directly upstream of the datapath. Every datapath control strobe comes from this block. Every datapath status flag terminates here.

## Interface
Parameters:
- none; the timeout feature is selected by macro (see Configuration).

Ports:
- `clock` in 1: single system clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high; forces state `inicial` on the next edge.
- `iniciar` in 1: start/restart request; level-sampled in `inicial` and the three end states only.
- `jogada_feita` in 1: one-cycle play pulse from the datapath edge detector.
- `botoesIgualMemoria` in 1: registered play equals ROM data.
- `endecoIgualLimite` in 1: address counter equals the current round limit.
- `fimL` in 1: limit counter at 15, meaning the last round.
- `timeout` in 1: play-timer terminal pulse.
- `zeraE`, `contaE` out 1 each: clear and increment for the address counter.
- `zeraL`, `contaL` out 1 each: clear and increment for the limit counter.
- `zeraR`, `registraR` out 1 each: clear and load for the play register.
- `contaT` out 1: play-timer run; low clears the timer.
- `pronto` out 1: game over.
- `acertou` out 1: game over, all 16 rounds correct.
- `errou` out 1: game over, wrong play.
- `db_timeout` out 1: game over by timeout.
- `db_estado` out 4: current state code.

## Operation
- The state register is 4 bits. Outputs decode from state only (Moore). No output depends combinationally on any input.
- States, with codes, asserted outputs and next state:
  - 0 `inicial`: no outputs asserted. Next: `iniciar`=1 → 1; otherwise stay.
  - 1 `preparacao`: `zeraE`, `zeraL`, `zeraR`. Next: 2.
  - 2 `inicio_rodada`: `zeraE`. Next: 3.
  - 3 `espera_jogada`: `contaT`. Next, in priority order:
    - `jogada_feita` → 4
    - `timeout` → 0xE
    - otherwise stay.
  - 4 `registra`: `registraR`. Next: 5.
  - 5 `comparacao`: no outputs asserted. Next, in priority order:
    - `botoesIgualMemoria`=0 → 0xF
    - `endecoIgualLimite`=0 → 6
    - `fimL`=1 → 0xA
    - otherwise → 7.
  - 6 `proxima_jogada`: `contaE`. Next: 3.
  - 7 `proxima_rodada`: `contaL`. Next: 2.
  - 0xA `fim_acertou`: `pronto`, `acertou`. Next: `iniciar`=1 → 1.
  - 0xE `fim_timeout`: `pronto`, `db_timeout`. Next: `iniciar`=1 → 1.
  - 0xF `fim_errou`: `pronto`, `errou`. Next: `iniciar`=1 → 1.
- Unused codes (8, 9, B, C, D) go to 0 on the next edge with all outputs low.
- `iniciar` is ignored outside states 0, A, E and F.
- `jogada_feita` is ignored outside state 3. A pulse arriving elsewhere is lost.
- If `jogada_feita` and `timeout` are high in the same cycle in state 3, the play wins (→ 4).
- Round k (k = 0..15) compares k+1 plays.

## Timing
- Reset: the state is 0 on the edge after `reset`=1. `reset` overrides any transition, including mid-round. All outputs are 0 and `db_estado`=0 while in state 0.
- Play path, from the edge that enters state 3 with `jogada_feita` high:
  - `registraR` is high for exactly one cycle (state 4).
  - The compare result is sampled one cycle later (state 5). Register and synchronous ROM are both settled by then.
- Play-to-next-wait latency is 4 cycles (3→4→5→6→3). A round change takes 5 cycles (3→4→5→7→2→3).
- `contaT` is high only in state 3. Leaving state 3 clears the timer (its clear is tied to `contaT` low), so each play gets a fresh timeout window.
- Each clear and count strobe lasts exactly one cycle per state visit.
- End-state outputs hold until `iniciar` is seen.

## Configuration
- `UC_TIMEOUT_EN` defined: behaviour exactly as above.
- `UC_TIMEOUT_EN` undefined:
  - `contaT` is tied 0.
  - The `timeout` input is ignored; state 3 waits indefinitely.
  - State 0xE is unreachable, and `db_timeout` is tied 0.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles, `iniciar`=0. Required: `db_estado`=0 and every output 0 for 10 cycles.
- Round 0 hit: `iniciar` pulse, then in state 3 `jogada_feita` with `botoesIgualMemoria`=1, `endecoIgualLimite`=1, `fimL`=0. Required sequence 0,1,2,3,4,5,7,2,3. `contaL` must be high exactly one cycle.
- Miss: in state 5 with `botoesIgualMemoria`=0. Required: state 0xF, `pronto`=`errou`=1, and the state holds for 20 cycles until `iniciar` → 1.
- Full win: 16 rounds of correct plays, with `fimL`=1 on the last round. Required: state 0xA, `acertou`=1, and 136 `registraR` pulses in total.
- Timeout (macro defined): hold state 3 and assert `timeout`. Required: 0xE with `db_timeout`=1. Same stimulus with the macro undefined: the state remains 3 and `contaT`=0.
- Simultaneous events and reset mid-operation:
  - `jogada_feita` and `timeout` together in state 3 → 4.
  - `reset` asserted in state 6 → state 0 on the next edge.

Source files
------------

// File: rtl/unidade_controle.sv
// Moore control unit sequencing the memory-game datapath.
// Define UC_TIMEOUT_EN to enable the play timer and the timeout end state.
module unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       botoesIgualMemoria,
    input  logic       endecoIgualLimite,
    input  logic       fimL,
    input  logic       timeout,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       contaT,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOU    = 4'hA,
        FIM_TIMEOUT    = 4'hE,
        FIM_ERROU      = 4'hF
    } estado_t;

    typedef struct packed {
        logic zeraE;
        logic contaE;
        logic zeraL;
        logic contaL;
        logic zeraR;
        logic registraR;
        logic contaT;
        logic pronto;
        logic acertou;
        logic errou;
        logic db_timeout;
    } saidas_t;

    estado_t estado_q, estado_d;
    saidas_t saidas_q, saidas_d;

`ifndef UC_TIMEOUT_EN
    logic unused_timeout;
    assign unused_timeout = timeout;
`endif

    function automatic saidas_t decodifica(input estado_t s);
        saidas_t o;
        o = '0;
        case (s)
            PREPARACAO: begin
                o.zeraE = 1'b1;
                o.zeraL = 1'b1;
                o.zeraR = 1'b1;
            end
            INICIO_RODADA:  o.zeraE = 1'b1;
`ifdef UC_TIMEOUT_EN
            ESPERA_JOGADA:  o.contaT = 1'b1;
`endif
            REGISTRA:       o.registraR = 1'b1;
            PROXIMA_JOGADA: o.contaE = 1'b1;
            PROXIMA_RODADA: o.contaL = 1'b1;
            FIM_ACERTOU: begin
                o.pronto  = 1'b1;
                o.acertou = 1'b1;
            end
`ifdef UC_TIMEOUT_EN
            FIM_TIMEOUT: begin
                o.pronto     = 1'b1;
                o.db_timeout = 1'b1;
            end
`endif
            FIM_ERROU: begin
                o.pronto = 1'b1;
                o.errou  = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:
                estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:
                estado_d = INICIO_RODADA;
            INICIO_RODADA:
                estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A play in the same cycle as a timeout wins.
                if (jogada_feita)
                    estado_d = REGISTRA;
`ifdef UC_TIMEOUT_EN
                else if (timeout)
                    estado_d = FIM_TIMEOUT;
`endif
                else
                    estado_d = ESPERA_JOGADA;
            end
            REGISTRA:
                estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!botoesIgualMemoria)
                    estado_d = FIM_ERROU;
                else if (!endecoIgualLimite)
                    estado_d = PROXIMA_JOGADA;
                else if (fimL)
                    estado_d = FIM_ACERTOU;
                else
                    estado_d = PROXIMA_RODADA;
            end
            PROXIMA_JOGADA:
                estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA:
                estado_d = INICIO_RODADA;
            FIM_ACERTOU:
                estado_d = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_TIMEOUT:
                estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
            FIM_ERROU:
                estado_d = iniciar ? PREPARACAO : FIM_ERROU;
            default:
                estado_d = INICIAL;
        endcase
        saidas_d = decodifica(estado_d);
    end

    // Outputs are registered from the next state so they track the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            saidas_q <= '0;
        end else begin
            estado_q <= estado_d;
            saidas_q <= saidas_d;
        end
    end

    assign zeraE      = saidas_q.zeraE;
    assign contaE     = saidas_q.contaE;
    assign zeraL      = saidas_q.zeraL;
    assign contaL     = saidas_q.contaL;
    assign zeraR      = saidas_q.zeraR;
    assign registraR  = saidas_q.registraR;
    assign contaT     = saidas_q.contaT;
    assign pronto     = saidas_q.pronto;
    assign acertou    = saidas_q.acertou;
    assign errou      = saidas_q.errou;
    assign db_timeout = saidas_q.db_timeout;
    assign db_estado  = estado_q;

endmodule
